// File: rtl/risc_pkg.sv
// Shared widths and register-index helpers for the operand-fetch slice.
package risc_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 16;
    localparam int OP_W       = 5;
    localparam int IDX_W      = $clog2(NUM_REGS);

    localparam logic [REG_ADDR_W-1:0] R0 = '0;

    // Any index that is zero or beyond the implemented bank behaves as r0.
    function automatic logic is_legal(input logic [REG_ADDR_W-1:0] idx);
        return (idx != R0) && (int'(idx) < NUM_REGS);
    endfunction

    // Narrow a register index to the scoreboard width; only meaningful when is_legal().
    function automatic logic [IDX_W-1:0] to_idx(input logic [REG_ADDR_W-1:0] idx);
        return idx[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits tracking in-flight writes; r0 and illegal indices never go busy.
module reg_scoreboard
    import risc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] rd1_idx,
    output logic                  rd1_busy,
    input  logic [REG_ADDR_W-1:0] rd2_idx,
    output logic                  rd2_busy,
    input  logic [REG_ADDR_W-1:0] dr_idx,
    output logic                  dr_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Next busy vector: clear first, then set, so a same-index set wins.
    always_comb begin
        // NOTE: assign a full default before any conditional update so no latch is inferred.
        busy_next = busy;
        if (clr_en && is_legal(clr_idx)) busy_next[to_idx(clr_idx)] = 1'b0;
        if (set_en && is_legal(set_idx)) busy_next[to_idx(set_idx)] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Busy register; async reset drops every pending write.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: this small bit-vector is reset on purpose; a stale busy bit would deadlock issue.
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    // Read ports: out-of-range and r0 lookups always report not-busy.
    always_comb begin
        rd1_busy = is_legal(rd1_idx) ? busy[to_idx(rd1_idx)] : 1'b0;
        rd2_busy = is_legal(rd2_idx) ? busy[to_idx(rd2_idx)] : 1'b0;
        dr_busy  = is_legal(dr_idx)  ? busy[to_idx(dr_idx)]  : 1'b0;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register read, writeback forwarding, hazard stall, output register.
module operand_fetch
    import risc_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_op,
    input  logic [REG_ADDR_W-1:0]        in_sr1,
    input  logic [REG_ADDR_W-1:0]        in_sr2,
    input  logic [REG_ADDR_W-1:0]        in_dr,
    input  logic                         in_wen,
    input  logic                         in_use_imm,
    input  logic signed [DATA_W-1:0]     in_imm,
    output logic [REG_ADDR_W-1:0]        sr1,
    output logic [REG_ADDR_W-1:0]        sr2,
    input  logic signed [DATA_W-1:0]     rData1,
    input  logic signed [DATA_W-1:0]     rData2,
    input  logic                         wb_valid,
    input  logic [REG_ADDR_W-1:0]        wb_dr,
    input  logic signed [DATA_W-1:0]     wb_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OP_W-1:0]              out_op,
    output logic signed [DATA_W-1:0]     out_a,
    output logic signed [DATA_W-1:0]     out_b,
    output logic [REG_ADDR_W-1:0]        out_dr,
    output logic                         out_wen
);

    logic busy1, busy2, busy_dr;
    logic hit1, hit2, hit_dr;
    logic hazard, issue;
    logic signed [DATA_W-1:0] op_a, op_b;

    assign sr1 = in_sr1;
    assign sr2 = in_sr2;

    reg_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue && in_wen),
        .set_idx  (in_dr),
        .clr_en   (wb_valid),
        .clr_idx  (wb_dr),
        .rd1_idx  (in_sr1),
        .rd1_busy (busy1),
        .rd2_idx  (in_sr2),
        .rd2_busy (busy2),
        .dr_idx   (in_dr),
        .dr_busy  (busy_dr)
    );

    // Hazard detection and handshake: a same-cycle writeback resolves a pending hazard.
    always_comb begin
        hit1     = wb_valid && (wb_dr == in_sr1);
        hit2     = wb_valid && (wb_dr == in_sr2);
        hit_dr   = wb_valid && (wb_dr == in_dr);
        hazard   = (busy1 && !hit1)
                 || (!in_use_imm && busy2 && !hit2)
                 || (in_wen && busy_dr && !hit_dr);
        in_ready = !hazard && (!out_valid || out_ready);
        issue    = in_valid && in_ready;
    end

    // Operand select: r0 first, then forwarded writeback, then bank data.
    always_comb begin
        if (!is_legal(in_sr1)) op_a = '0;
        else if (hit1)         op_a = wb_data;
        else                   op_a = rData1;

        if (in_use_imm)             op_b = in_imm;
        else if (!is_legal(in_sr2)) op_b = '0;
        else if (hit2)              op_b = wb_data;
        else                        op_b = rData2;
    end

    // Output register: load on issue, drain when consumed, hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_dr    <= '0;
            out_wen   <= 1'b0;
        end else if (issue) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_a     <= op_a;
            out_b     <= op_b;
            out_dr    <= in_dr;
            out_wen   <= in_wen;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_op, in_sr1, in_sr2, in_dr;
    logic        in_wen, in_use_imm;
    logic [31:0] in_imm;
    logic [4:0]  sr1, sr2;
    logic [31:0] rData1, rData2;
    logic        wb_valid;
    logic [4:0]  wb_dr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_op;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_dr;
    logic        out_wen;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_sr1     (in_sr1),
        .in_sr2     (in_sr2),
        .in_dr      (in_dr),
        .in_wen     (in_wen),
        .in_use_imm (in_use_imm),
        .in_imm     (in_imm),
        .sr1        (sr1),
        .sr2        (sr2),
        .rData1     (rData1),
        .rData2     (rData2),
        .wb_valid   (wb_valid),
        .wb_dr      (wb_dr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_dr     (out_dr),
        .out_wen    (out_wen)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic w, input logic ui, input logic [31:0] imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_sr1     = s1;
        in_sr2     = s2;
        in_dr      = d;
        in_wen     = w;
        in_use_imm = ui;
        in_imm     = imm;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_op = 0; in_sr1 = 0; in_sr2 = 0; in_dr = 0;
        in_wen = 0; in_use_imm = 0; in_imm = 0;
        rData1 = 0; rData2 = 0; wb_valid = 0; wb_dr = 0; wb_data = 0;
        out_ready = 1'b1;

        // 1. reset state
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(dut.u_sb.busy), 32'h0);
        check("rst_out_a", out_a, 32'h0);

        // 2. basic issue with bank data
        drive(5'd3, 5'd2, 5'd5, 5'd4, 1'b1, 1'b0, 32'h0);
        rData1 = 32'd7;
        rData2 = 32'hFFFF_FFF7;
        #1;
        check("t2_in_ready", 32'(in_ready), 32'd1);
        check("t2_sr_addr", {22'd0, sr1, sr2}, {22'd0, 5'd2, 5'd5});
        tick();
        in_valid = 1'b0;
        check("t2_out_a", out_a, 32'd7);
        check("t2_out_b", out_b, 32'hFFFF_FFF7);
        check("t2_out_dr", 32'(out_dr), 32'd4);
        check("t2_out_op", 32'(out_op), 32'd3);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_busy", 32'(dut.u_sb.busy), 32'h0010);

        // 3. RAW stall on r4, resolved by same-cycle writeback
        drive(5'd1, 5'd4, 5'd1, 5'd6, 1'b1, 1'b0, 32'h0);
        rData1 = 32'h0000_DEAD;
        rData2 = 32'd11;
        #1;
        check("t3_stall0", 32'(in_ready), 32'd0);
        tick();
        check("t3_drained", 32'(out_valid), 32'd0);
        check("t3_stall1", 32'(in_ready), 32'd0);
        tick();
        check("t3_stall2", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_dr = 5'd4; wb_data = 32'd100;
        #1;
        check("t3_fwd_ready", 32'(in_ready), 32'd1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        check("t3_out_a", out_a, 32'd100);
        check("t3_out_b", out_b, 32'd11);
        check("t3_out_dr", 32'(out_dr), 32'd6);
        check("t3_busy", 32'(dut.u_sb.busy), 32'h0040);

        // 4. back-pressure: out_ready low for 3 cycles with an instruction waiting
        out_ready = 1'b0;
        drive(5'd9, 5'd3, 5'd7, 5'd8, 1'b0, 1'b1, 32'hFFFF_FFFE);
        rData1 = 32'h33;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_bp_ready", 32'(in_ready), 32'd0);
            check("t4_bp_a", out_a, 32'd100);
            check("t4_bp_dr", 32'(out_dr), 32'd6);
            check("t4_bp_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("t4_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("t4_out_a", out_a, 32'h33);
        check("t4_out_b", out_b, 32'hFFFF_FFFE);
        check("t4_out_op", 32'(out_op), 32'd9);
        check("t4_out_dr", 32'(out_dr), 32'd8);
        check("t4_out_wen", 32'(out_wen), 32'd0);

        // 5. r0 and out-of-range index 17 read zero and never go busy
        drive(5'd2, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
        rData1 = 32'h55; rData2 = 32'h55;
        tick();
        check("t5_r0_a", out_a, 32'h0);
        check("t5_r0_b", out_b, 32'h0);
        check("t5_r0_busy", 32'(dut.u_sb.busy), 32'h0040);
        drive(5'd2, 5'd17, 5'd17, 5'd17, 1'b1, 1'b0, 32'h0);
        #1;
        check("t5_r17_ready", 32'(in_ready), 32'd1);
        tick();
        check("t5_r17_a", out_a, 32'h0);
        check("t5_r17_dr", 32'(out_dr), 32'd17);
        check("t5_r17_busy", 32'(dut.u_sb.busy), 32'h0040);

        // writeback to busy r6 clears it; writeback to non-busy r9 changes nothing
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_dr = 5'd6; wb_data = 32'd1;
        tick();
        wb_dr = 5'd9;
        tick();
        wb_valid = 1'b0;
        check("t5_wb_clear", 32'(dut.u_sb.busy), 32'h0);

        // 6. async reset with out_valid=1, busy[4]=1, out_ready=0
        drive(5'd4, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_busy", 32'(dut.u_sb.busy), 32'h0010);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_busy", 32'(dut.u_sb.busy), 32'h0);
        check("t6_async_dr", 32'(out_dr), 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t6_post_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
